cordic_scheduler: RTL

Round-robin scheduler that shares one iterative CORDIC sine/cosine engine between NREQ requesters. It accepts one 8-bit angle request at a time and launches the engine with a single start pulse. It then waits for the engine's done strobe, or for a watchdog timeout. Finally it returns the result with the requester ID over a valid/ready response channel. It sits between the client blocks and the cordic core.

---
 rtl/cordic_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cordic_scheduler.sv
// Round-robin arbiter that time-shares one iterative CORDIC engine.
// One request in flight; watchdog turns a silent engine into an error reply.
module cordic_scheduler #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_angle,
    output logic [NREQ-1:0]   req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [7:0]        resp_sine,
    output logic [7:0]        resp_cosine,
    output logic              resp_err,
    output logic              core_start,
    output logic [7:0]        core_angle,
    input  logic              core_done,
    input  logic [7:0]        core_sine,
    input  logic [7:0]        core_cosine,
    output logic              busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IDW-1:0]  r_ptr;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_angle;
    logic [IDW-1:0]  r_id;
    logic [7:0]      r_sine;
    logic [7:0]      r_cos;
    logic            r_err;

    logic            w_any;
    logic [IDW-1:0]  w_grant;
    logic [IW-1:0]   w_idx;
    logic [NREQ-1:0] w_onehot;
    logic [7:0]      w_angle;
    logic            w_timeout;

    // Search downward so the nearest valid index after the pointer wins.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = IW'((int'(r_ptr) + k) % NREQ);
            if (req_valid[w_idx]) begin
                w_any   = 1'b1;
                w_grant = IDW'(w_idx);
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        w_angle  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_any && w_grant == IDW'(i)) begin
                w_onehot[i] = 1'b1;
                w_angle     = req_angle[i*8 +: 8];
            end
        end
    end

    assign w_timeout = (r_cnt == LAST);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_any) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (core_done || w_timeout) w_next = S_RESP;
            S_RESP:  if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ptr   <= IDW'(NREQ - 1);
            r_cnt   <= '0;
            r_angle <= '0;
            r_id    <= '0;
            r_sine  <= '0;
            r_cos   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_angle <= w_angle;
                        r_id    <= w_grant;
                        r_ptr   <= w_grant;
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    if (core_done) begin
                        r_sine <= core_sine;
                        r_cos  <= core_cosine;
                        r_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_sine <= '0;
                        r_cos  <= '0;
                        r_err  <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Grant is combinational but masked while reset is asserted.
    assign req_ready   = (rst && r_state == S_IDLE) ? w_onehot : '0;
    assign core_start  = (r_state == S_ISSUE);
    assign core_angle  = r_angle;
    assign resp_valid  = (r_state == S_RESP);
    assign resp_id     = r_id;
    assign resp_sine   = r_sine;
    assign resp_cosine = r_cos;
    assign resp_err    = r_err;
    assign busy        = (r_state != S_IDLE);

endmodule
